// File: rtl/ddr_ui_ws_bridge.sv
// Bridges a single-line Wishbone slave onto a DDR controller user interface
// (app_* command, write-data and read-return channels), one line per request.
module ddr_ui_ws_bridge #(
  parameter int LINE_BITS     = 512,
  parameter int UI_BITS       = 256,
  parameter int DQ_BITS       = 32,
  parameter int APP_ADDR_BITS = 28,
  parameter int POSTED_WRITE  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     calib_done,
  input  logic [31:0]              ws_addr,
  input  logic [LINE_BITS-1:0]     ws_din,
  input  logic [LINE_BITS/8-1:0]   ws_dm,
  input  logic                     ws_cyc,
  input  logic                     ws_stb,
  input  logic                     ws_we,
  output logic                     ws_ack,
  output logic [LINE_BITS-1:0]     ws_dout,
  output logic [APP_ADDR_BITS-1:0] app_addr,
  output logic [2:0]               app_cmd,
  output logic                     app_en,
  input  logic                     app_rdy,
  output logic [UI_BITS-1:0]       app_wdf_data,
  output logic [UI_BITS/8-1:0]     app_wdf_mask,
  output logic                     app_wdf_wren,
  output logic                     app_wdf_end,
  input  logic                     app_wdf_rdy,
  input  logic [UI_BITS-1:0]       app_rd_data,
  input  logic                     app_rd_data_valid,
  output logic [2:0]               dbg_state
);
  localparam int BEATS    = LINE_BITS / UI_BITS;
  localparam int STEP     = UI_BITS / DQ_BITS;
  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int IDX_BITS = 32 - OFF_BITS;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCNT_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(BEATS - 1);
  localparam logic [RCNT_W-1:0] ALL_BEATS = RCNT_W'(BEATS);

  localparam logic [2:0] S_CALIB    = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_WR_DATA  = 3'd2;
  localparam logic [2:0] S_WR_CMD   = 3'd3;
  localparam logic [2:0] S_RD       = 3'd4;
  localparam logic [2:0] S_RD_DRAIN = 3'd5;
  localparam logic [2:0] S_ACK      = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [IDX_BITS-1:0]    line_q, line_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS/8-1:0] wdm_q, wdm_d;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0]       ccnt_q, ccnt_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  logic [LINE_BITS-1:0]   dout_q, dout_d;
  logic                   ack_q, ack_d;
  logic                   rd_beat, rd_all;

  // Byte offset within a line does not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ws_addr[OFF_BITS-1:0];

  // Handshakes: a beat/command transfers on a rising edge where the bridge's
  // enable (app_en / app_wdf_wren) and the controller's ready are both 1;
  // app_rd_data_valid is a one-way push with no back-pressure.
  assign app_addr = APP_ADDR_BITS'((64'(line_q) * 64'(BEATS) + 64'(ccnt_q)) * 64'(STEP));
  assign app_en       = (state_q == S_WR_CMD) || (state_q == S_RD);
  assign app_cmd      = (state_q == S_WR_CMD) ? 3'b000 : 3'b001;
  assign app_wdf_wren = (state_q == S_WR_DATA);
  assign app_wdf_end  = (state_q == S_WR_DATA);
  assign app_wdf_data = wdata_q[dcnt_q*UI_BITS +: UI_BITS];
  assign app_wdf_mask = ~wdm_q[dcnt_q*(UI_BITS/8) +: UI_BITS/8];
  assign ws_ack       = ack_q || ((state_q == S_ACK) && ws_cyc);
  assign ws_dout      = dout_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    wdata_d = wdata_q;
    wdm_d   = wdm_q;
    dcnt_d  = dcnt_q;
    ccnt_d  = ccnt_q;
    rcnt_d  = rcnt_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;

    // Read returns can overlap the tail of the command phase.
    rd_beat = app_rd_data_valid && ((state_q == S_RD) || (state_q == S_RD_DRAIN));
    if (rd_beat) begin
      dout_d[rcnt_q[CNT_W-1:0]*UI_BITS +: UI_BITS] = app_rd_data;
      rcnt_d = rcnt_q + RCNT_W'(1);
    end
    rd_all = (rcnt_d == ALL_BEATS);

    case (state_q)
      S_CALIB: if (calib_done) state_d = S_IDLE;
      S_IDLE: begin
        if (ws_cyc && ws_stb) begin
          line_d  = ws_addr[31:OFF_BITS];
          wdata_d = ws_din;
          wdm_d   = ws_dm;
          dcnt_d  = '0;
          ccnt_d  = '0;
          rcnt_d  = '0;
          if (ws_we) begin
            state_d = S_WR_DATA;
            ack_d   = (POSTED_WRITE != 0);
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_WR_DATA: begin
        if (app_wdf_rdy) begin
          if (dcnt_q == LAST) begin
            dcnt_d  = '0;
            state_d = S_WR_CMD;
          end else begin
            dcnt_d = dcnt_q + CNT_W'(1);
          end
        end
      end
      S_WR_CMD: begin
        if (app_rdy) begin
          if (ccnt_q == LAST) begin
            ccnt_d  = '0;
            state_d = (POSTED_WRITE != 0) ? S_IDLE : S_ACK;
          end else begin
            ccnt_d = ccnt_q + CNT_W'(1);
          end
        end
      end
      S_RD: begin
        if (app_rdy) begin
          if (ccnt_q == LAST) begin
            ccnt_d  = '0;
            state_d = rd_all ? S_ACK : S_RD_DRAIN;
          end else begin
            ccnt_d = ccnt_q + CNT_W'(1);
          end
        end
      end
      S_RD_DRAIN: if (rd_all) state_d = S_ACK;
      S_ACK:      state_d = S_IDLE;
      default:    state_d = S_CALIB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CALIB;
      line_q  <= '0;
      wdata_q <= '0;
      wdm_q   <= '0;
      dcnt_q  <= '0;
      ccnt_q  <= '0;
      rcnt_q  <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      wdata_q <= wdata_d;
      wdm_q   <= wdm_d;
      dcnt_q  <= dcnt_d;
      ccnt_q  <= ccnt_d;
      rcnt_q  <= rcnt_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
    end
  end
endmodule

// File: tb/tb_ddr_ui_ws_bridge.sv
// Bench for ddr_ui_ws_bridge: a posted and a non-posted instance sit behind a
// cycle-level controller emulator; read lines are scored against a line-level memory model.
module tb_ddr_ui_ws_bridge;
  localparam int LINE_BITS = 512;
  localparam int UI_BITS   = 256;
  localparam int AW        = 28;

  typedef struct packed {
    logic [UI_BITS-1:0]   data;
    logic [UI_BITS/8-1:0] mask;
  } wdf_t;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [31:0]   cyc;
  } cmd_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, calib_done;
  logic [31:0]            ws_addr;
  logic [LINE_BITS-1:0]   ws_din;
  logic [LINE_BITS/8-1:0] ws_dm;
  logic                   ws_cyc, ws_stb, ws_we;
  logic                   app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [UI_BITS-1:0]     app_rd_data;
  int                     sel;
  logic                   cyc0, cyc1, stb0, stb1;

  logic                   ack_i      [2];
  logic [LINE_BITS-1:0]   dout_i     [2];
  logic [AW-1:0]          app_addr_i [2];
  logic [2:0]             app_cmd_i  [2];
  logic                   app_en_i   [2];
  logic [UI_BITS-1:0]     wdata_i    [2];
  logic [UI_BITS/8-1:0]   wmask_i    [2];
  logic                   wren_i     [2];
  logic                   wend_i     [2];
  logic [2:0]             dbg_i      [2];

  assign cyc0 = ws_cyc && (sel == 0);
  assign stb0 = ws_stb && (sel == 0);
  assign cyc1 = ws_cyc && (sel == 1);
  assign stb1 = ws_stb && (sel == 1);

  ddr_ui_ws_bridge #(.POSTED_WRITE(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
    .ws_cyc(cyc0), .ws_stb(stb0), .ws_we(ws_we),
    .ws_ack(ack_i[0]), .ws_dout(dout_i[0]),
    .app_addr(app_addr_i[0]), .app_cmd(app_cmd_i[0]), .app_en(app_en_i[0]), .app_rdy(app_rdy),
    .app_wdf_data(wdata_i[0]), .app_wdf_mask(wmask_i[0]), .app_wdf_wren(wren_i[0]),
    .app_wdf_end(wend_i[0]), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .dbg_state(dbg_i[0])
  );

  ddr_ui_ws_bridge #(.POSTED_WRITE(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm),
    .ws_cyc(cyc1), .ws_stb(stb1), .ws_we(ws_we),
    .ws_ack(ack_i[1]), .ws_dout(dout_i[1]),
    .app_addr(app_addr_i[1]), .app_cmd(app_cmd_i[1]), .app_en(app_en_i[1]), .app_rdy(app_rdy),
    .app_wdf_data(wdata_i[1]), .app_wdf_mask(wmask_i[1]), .app_wdf_wren(wren_i[1]),
    .app_wdf_end(wend_i[1]), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .dbg_state(dbg_i[1])
  );

  // ---------------- emulator + scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int rdy_mode, wdf_mode, ret_pct;
  int ack_count, ack_cyc, cap_cyc, seen_states;
  logic cur_we, drop_pending;

  wdf_t               wdf_q[$];
  wdf_t               wdf_log[$];
  cmd_t               cmd_log[$];
  logic [UI_BITS-1:0] ret_q[$];
  logic [UI_BITS-1:0] mem [int];
  logic [LINE_BITS-1:0] exp_line [int];
  logic [LINE_BITS-1:0] exp_q[$];

  function automatic logic [UI_BITS-1:0] rand_ui();
    logic [UI_BITS-1:0] r;
    for (int i = 0; i < UI_BITS / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] r;
    for (int i = 0; i < LINE_BITS / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int mkey(int s, int addr);
    return s * (1 << 28) + addr;
  endfunction

  // 0 random, 1 always, 2 never, 3 even cycles, 4 odd cycles
  function automatic logic pick(int mode);
    case (mode)
      0: return logic'($urandom_range(1));
      1: return 1'b1;
      2: return 1'b0;
      3: return (cyc_cnt % 2) == 0;
      default: return (cyc_cnt % 2) == 1;
    endcase
  endfunction

  // Line-level model: requested bytes of a write replace the stored line.
  task automatic start_req(input int s, input logic we, input logic [31:0] addr,
                           input logic [LINE_BITS-1:0] din, input logic [LINE_BITS/8-1:0] dm);
    int key;
    logic [LINE_BITS-1:0] line;
    sel = s;
    ws_cyc = 1'b1; ws_stb = 1'b1; ws_we = we;
    ws_addr = addr; ws_din = din; ws_dm = dm;
    cur_we = we; ack_count = 0; ack_cyc = -1; cap_cyc = -1; drop_pending = 1'b0;
    seen_states = 0;
    key = s * 100000000 + int'(addr[31:6]);
    line = exp_line.exists(key) ? exp_line[key] : '0;
    if (we) begin
      for (int b = 0; b < LINE_BITS / 8; b++) if (dm[b]) line[b*8 +: 8] = din[b*8 +: 8];
      exp_line[key] = line;
    end else begin
      exp_q.push_back(line);
    end
  endtask

  // One clock of controller emulation; entered and left at a falling edge.
  task automatic emu_cycle();
    int key;
    int st;
    wdf_t w;
    logic [UI_BITS-1:0] m;
    if (drop_pending) begin
      ws_cyc = 1'b0; ws_stb = 1'b0; drop_pending = 1'b0;
    end
    app_rdy     = pick(rdy_mode);
    app_wdf_rdy = pick(wdf_mode);
    if (ret_q.size() > 0 && $urandom_range(99) < ret_pct) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = ret_q.pop_front();
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data = rand_ui();
    end
    #1;
    st = int'(dbg_i[sel]);
    seen_states = seen_states | (1 << st);
    n_checks++;
    if (app_en_i[sel] !== (st == 3 || st == 4) || wren_i[sel] !== (st == 2) ||
        app_cmd_i[sel] !== ((st == 3) ? 3'b000 : 3'b001) || wend_i[sel] !== wren_i[sel]) begin
      n_fail++;
      $display("FAIL app_controls: state=%0d en=%b cmd=%b wren=%b end=%b", st,
               app_en_i[sel], app_cmd_i[sel], wren_i[sel], wend_i[sel]);
    end
    if (st == 1 && ws_cyc && ws_stb && cap_cyc < 0) cap_cyc = cyc_cnt;
    if (wren_i[sel] && app_wdf_rdy) begin
      w.data = wdata_i[sel]; w.mask = wmask_i[sel];
      wdf_q.push_back(w); wdf_log.push_back(w);
    end
    if (app_en_i[sel] && app_rdy) begin
      key = mkey(sel, int'(app_addr_i[sel]));
      cmd_log.push_back('{cmd: app_cmd_i[sel], addr: app_addr_i[sel], cyc: cyc_cnt});
      m = mem.exists(key) ? mem[key] : '0;
      if (app_cmd_i[sel] == 3'b000) begin
        n_checks++;
        if (wdf_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_cmd_data: got 0 queued beats required >=1");
        end else begin
          w = wdf_q.pop_front();
          for (int b = 0; b < UI_BITS / 8; b++) if (!w.mask[b]) m[b*8 +: 8] = w.data[b*8 +: 8];
          mem[key] = m;
        end
      end else begin
        ret_q.push_back(m);
      end
    end
    if (ack_i[sel]) begin
      ack_count++; ack_cyc = cyc_cnt; drop_pending = 1'b1;
      if (!cur_we) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL read_ack: got ack with no read outstanding");
        end else begin
          m = '0;
          if (dout_i[sel] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL read_line: got %h required %h", dout_i[sel], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    cyc_cnt++;
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (ack_count > 0 && !drop_pending && !ws_cyc && dbg_i[sel] == 3'd1) break;
      emu_cycle();
    end
    n_checks++;
    if (i == budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got no completion after %0d cycles", name, budget);
      ws_cyc = 1'b0; ws_stb = 1'b0;
    end
    n_checks++;
    if (ack_count != 1) begin
      n_fail++;
      $display("FAIL %s_ack_count: got %0d required 1", name, ack_count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; calib_done = 1'b0; sel = 0;
    ws_cyc = 1'b0; ws_stb = 1'b0; ws_we = 1'b0; ws_addr = '0; ws_din = '0; ws_dm = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = '0;
    rdy_mode = 1; wdf_mode = 1; ret_pct = 100; drop_pending = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (dbg_i[s] !== 3'd0 || ack_i[s] !== 1'b0 || app_en_i[s] !== 1'b0 ||
          wren_i[s] !== 1'b0 || dout_i[s] !== '0 || app_cmd_i[s] !== 3'b001) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: state=%0d ack=%b en=%b wren=%b cmd=%b required 0,0,0,0,001",
                 s, dbg_i[s], ack_i[s], app_en_i[s], wren_i[s], app_cmd_i[s]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_calib();
    logic [UI_BITS-1:0] a, b;
    a = rand_ui(); b = rand_ui();
    mem[mkey(0, 80)] = a; mem[mkey(0, 88)] = b;
    exp_line[5] = {b, a};
    cmd_log.delete();
    start_req(0, 1'b0, 32'h0000_0140, '0, '0);
    repeat (20) emu_cycle();
    n_checks++;
    if (cmd_log.size() != 0 || ack_count != 0 || dbg_i[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL calib_hold: cmds=%0d acks=%0d state=%0d required 0,0,0",
               cmd_log.size(), ack_count, dbg_i[0]);
    end
    calib_done = 1'b1;
    run_until_done(40, "calib_read");
  endtask

  task automatic test_posted_write();
    logic [LINE_BITS-1:0] din;
    din = rand_line();
    wdf_log.delete(); cmd_log.delete();
    rdy_mode = 3; wdf_mode = 4;
    start_req(0, 1'b1, 32'h0000_0040, din, ~64'h1);
    run_until_done(60, "posted_write");
    n_checks++;
    if (wdf_log.size() != 2 || cmd_log.size() != 2) begin
      n_fail++;
      $display("FAIL pw_counts: got %0d beats %0d cmds required 2,2", wdf_log.size(), cmd_log.size());
    end else begin
      n_checks++;
      if (wdf_log[0].data !== din[255:0] || wdf_log[1].data !== din[511:256]) begin
        n_fail++;
        $display("FAIL pw_wdf_data: got %h %h required %h", wdf_log[1].data, wdf_log[0].data, din);
      end
      n_checks++;
      if (wdf_log[0].mask !== 32'h0000_0001 || wdf_log[1].mask !== 32'h0000_0000) begin
        n_fail++;
        $display("FAIL pw_wdf_mask: got %h %h required 00000001 00000000",
                 wdf_log[0].mask, wdf_log[1].mask);
      end
      n_checks++;
      if (cmd_log[0].addr !== 28'h10 || cmd_log[1].addr !== 28'h18 ||
          cmd_log[0].cmd !== 3'b000 || cmd_log[1].cmd !== 3'b000) begin
        n_fail++;
        $display("FAIL pw_cmds: got %h/%b %h/%b required 10/000 18/000",
                 cmd_log[0].addr, cmd_log[0].cmd, cmd_log[1].addr, cmd_log[1].cmd);
      end
    end
    n_checks++;
    if (ack_cyc != cap_cyc + 1) begin
      n_fail++;
      $display("FAIL pw_ack_timing: got ack at %0d required %0d", ack_cyc, cap_cyc + 1);
    end
    rdy_mode = 1; wdf_mode = 1;
  endtask

  task automatic test_read_overlap();
    logic [LINE_BITS-1:0] held;
    int i;
    cmd_log.delete();
    rdy_mode = 1; ret_pct = 100;
    start_req(0, 1'b0, 32'h0000_0040, '0, '0);
    held = exp_q[exp_q.size()-1];
    for (i = 0; i < 20 && cmd_log.size() < 1; i++) emu_cycle();
    rdy_mode = 2;
    repeat (3) emu_cycle();
    n_checks++;
    if (dbg_i[0] !== 3'd4 || cmd_log.size() != 1) begin
      n_fail++;
      $display("FAIL rd_stall: state=%0d cmds=%0d required 4,1", dbg_i[0], cmd_log.size());
    end
    rdy_mode = 1;
    run_until_done(30, "read_overlap");
    n_checks++;
    if ((seen_states & (1 << 5)) == 0) begin
      n_fail++;
      $display("FAIL rd_drain_path: got states %b required bit5 set", seen_states[7:0]);
    end
    repeat (5) emu_cycle();
    n_checks++;
    if (dout_i[0] !== held) begin
      n_fail++;
      $display("FAIL rd_hold: got %h required %h", dout_i[0], held);
    end
  endtask

  task automatic test_nonposted_write();
    int i;
    cmd_log.delete();
    wdf_mode = 1; rdy_mode = 2;
    start_req(1, 1'b1, 32'h0000_01c0, rand_line(), '1);
    for (i = 0; i < 20 && dbg_i[1] !== 3'd3; i++) emu_cycle();
    repeat (10) emu_cycle();
    n_checks++;
    if (ack_count != 0 || cmd_log.size() != 0) begin
      n_fail++;
      $display("FAIL np_early_ack: got acks=%0d cmds=%0d required 0,0", ack_count, cmd_log.size());
    end
    rdy_mode = 1;
    run_until_done(30, "nonposted_write");
    n_checks++;
    if (cmd_log.size() != 2) begin
      n_fail++;
      $display("FAIL np_cmds: got %0d required 2", cmd_log.size());
    end else begin
      n_checks++;
      if (ack_cyc != int'(cmd_log[1].cyc) + 1 || cmd_log[0].addr !== 28'h70 || cmd_log[1].addr !== 28'h78) begin
        n_fail++;
        $display("FAIL np_ack_timing: ack at %0d addrs %h %h required %0d 70 78",
                 ack_cyc, cmd_log[0].addr, cmd_log[1].addr, int'(cmd_log[1].cyc) + 1);
      end
    end
    start_req(1, 1'b0, 32'h0000_01c0, '0, '0);
    run_until_done(30, "nonposted_readback");
  endtask

  task automatic test_reset_mid_read();
    int i;
    rdy_mode = 1; ret_pct = 0;
    start_req(0, 1'b0, 32'h0000_0140, '0, '0);
    for (i = 0; i < 20 && dbg_i[0] !== 3'd5; i++) emu_cycle();
    n_checks++;
    if (dbg_i[0] !== 3'd5) begin
      n_fail++;
      $display("FAIL mid_reach_drain: got state %0d required 5", dbg_i[0]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dbg_i[0] !== 3'd0 || ack_i[0] !== 1'b0 || app_en_i[0] !== 1'b0 ||
        wren_i[0] !== 1'b0 || dout_i[0] !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: state=%0d ack=%b en=%b wren=%b dout_zero=%b required 0,0,0,0,1",
               dbg_i[0], ack_i[0], app_en_i[0], wren_i[0], dout_i[0] == '0);
    end
    exp_q.delete();
    ws_cyc = 1'b0; ws_stb = 1'b0; drop_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ret_pct = 100;
    repeat (4) emu_cycle();
    n_checks++;
    if (dout_i[0] !== '0 || dbg_i[0] !== 3'd1 || ret_q.size() != 0) begin
      n_fail++;
      $display("FAIL late_beat: dout_zero=%b state=%0d pending=%0d required 1,1,0",
               dout_i[0] == '0, dbg_i[0], ret_q.size());
    end
    ret_q.delete(); wdf_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] line, addr;
    logic [LINE_BITS/8-1:0] dm;
    rdy_mode = 0; wdf_mode = 0; ret_pct = 60;
    for (int t = 0; t < 40; t++) begin
      line = ($urandom_range(7) == 0) ? 32'h00FF_FFFF : 32'($urandom_range(15));
      addr = {line[25:0], 6'($urandom_range(63))};
      dm = ($urandom_range(3) == 0) ? '1 : {$urandom(), $urandom()};
      start_req(int'($urandom_range(1)), logic'($urandom_range(1)), addr, rand_line(), dm);
      run_until_done(200, "random_txn");
    end
  endtask

  initial begin
    test_reset();
    test_calib();
    test_posted_write();
    test_read_overlap();
    test_nonposted_write();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
